// File: rtl/wm_pkg.sv
// Shared state encoding, mode constants and phase-length scaling for the wash cycle controller.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_DONE  = 3'd6
  } wm_state_t;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_QUICK  = 2'd1;
  localparam logic [1:0] MODE_HEAVY  = 2'd2;
  localparam logic [1:0] MODE_RINSE  = 2'd3;

  // Quick halves every phase (never below one cycle); heavy doubles only the wash.
  function automatic int unsigned scale_len(input int unsigned base, input logic [1:0] md,
                                            input logic is_wash);
    int unsigned len;
    len = base;
    if (md == MODE_QUICK) begin
      len = ((base >> 1) == 0) ? 1 : (base >> 1);
    end else if ((md == MODE_HEAVY) && is_wash) begin
      len = base << 1;
    end
    return len;
  endfunction

endpackage

// File: rtl/wm_cycle_ctrl_timer.sv
// Loadable phase down-counter: holds when asked, stops at zero, flags zero.
module wm_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_hold,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/wm_cycle_ctrl.sv
// Programme sequencer: fill, wash, drain, rinse passes, spin, with pause, door interlock and abort.
module wm_cycle_ctrl
  import wm_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int FILL_T  = 4,
  parameter int WASH_T  = 10,
  parameter int RINSE_T = 6,
  parameter int DRAIN_T = 3,
  parameter int SPIN_T  = 8,
  parameter int N_RINSE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       pause,
  input  logic       door_open,
  input  logic       abort,
  output logic       fill,
  output logic       wash,
  output logic       rinse,
  output logic       drain,
  output logic       spin,
  output logic       busy,
  output logic       paused,
  output logic       done,
  output logic       aborted,
  output logic [2:0] state
);

  wm_state_t        r_state;
  logic [1:0]       r_mode;
  logic [7:0]       r_ridx;
  logic             r_abt;
  logic             r_paused;

  wm_state_t        w_state_n;
  logic [1:0]       w_mode_n;
  logic [7:0]       w_ridx_n;
  logic [7:0]       w_rcnt;
  logic             w_abt_n;
  logic             w_paused_n;
  logic             w_done_n;
  logic             w_abtd_n;
  logic             w_load;
  int unsigned      w_len;
  logic [CNT_W-1:0] w_load_val;
  logic             w_zero;
  logic             w_phase;
  logic             w_phase_n;
  logic             w_active;

  wm_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_hold     (!w_active),
    .o_zero     (w_zero)
  );

  assign w_phase    = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_active   = w_phase && !r_paused;
  assign w_rcnt     = 8'(N_RINSE) + ((r_mode == MODE_HEAVY) ? 8'd1 : 8'd0);
  assign w_load_val = CNT_W'(w_len - 1);
  assign state      = r_state;

  always_comb begin
    w_state_n = r_state;
    w_mode_n  = r_mode;
    w_ridx_n  = r_ridx;
    w_abt_n   = r_abt;
    w_done_n  = 1'b0;
    w_abtd_n  = 1'b0;
    w_load    = 1'b0;
    w_len     = 1;
    case (r_state)
      ST_IDLE: begin
        if (start && !door_open) begin
          w_state_n = ST_FILL;
          w_mode_n  = mode;
          w_ridx_n  = (mode == MODE_RINSE) ? 8'd1 : 8'd0;
          w_abt_n   = 1'b0;
          w_load    = 1'b1;
          w_len     = scale_len(FILL_T, mode, 1'b0);
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
        w_abt_n   = 1'b0;
      end
      ST_FILL, ST_WASH, ST_DRAIN, ST_RINSE, ST_SPIN: begin
        if (abort && !r_abt) begin
          w_state_n = ST_DRAIN;
          w_abt_n   = 1'b1;
          w_load    = 1'b1;
          w_len     = scale_len(DRAIN_T, r_mode, 1'b0);
        end else if (!r_paused && w_zero) begin
          // r_ridx == 0 marks the fill/drain pair around the wash.
          case (r_state)
            ST_FILL: begin
              w_load = 1'b1;
              if (r_ridx == 8'd0) begin
                w_state_n = ST_WASH;
                w_len     = scale_len(WASH_T, r_mode, 1'b1);
              end else begin
                w_state_n = ST_RINSE;
                w_len     = scale_len(RINSE_T, r_mode, 1'b0);
              end
            end
            ST_WASH, ST_RINSE: begin
              w_state_n = ST_DRAIN;
              w_load    = 1'b1;
              w_len     = scale_len(DRAIN_T, r_mode, 1'b0);
            end
            ST_DRAIN: begin
              if (r_abt) begin
                w_state_n = ST_DONE;
                w_abtd_n  = 1'b1;
              end else if (r_ridx < w_rcnt) begin
                w_state_n = ST_FILL;
                w_ridx_n  = r_ridx + 8'd1;
                w_load    = 1'b1;
                w_len     = scale_len(FILL_T, r_mode, 1'b0);
              end else begin
                w_state_n = ST_SPIN;
                w_load    = 1'b1;
                w_len     = scale_len(SPIN_T, r_mode, 1'b0);
              end
            end
            ST_SPIN: begin
              w_state_n = ST_DONE;
              w_done_n  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign w_phase_n  = (w_state_n != ST_IDLE) && (w_state_n != ST_DONE);
  assign w_paused_n = (pause || door_open) && w_phase_n && !w_abt_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_mode   <= '0;
      r_ridx   <= '0;
      r_abt    <= 1'b0;
      r_paused <= 1'b0;
      fill     <= 1'b0;
      wash     <= 1'b0;
      rinse    <= 1'b0;
      drain    <= 1'b0;
      spin     <= 1'b0;
      busy     <= 1'b0;
      paused   <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_mode   <= w_mode_n;
      r_ridx   <= w_ridx_n;
      r_abt    <= w_abt_n;
      r_paused <= w_paused_n;
      fill     <= (w_state_n == ST_FILL)  && !w_paused_n;
      wash     <= (w_state_n == ST_WASH)  && !w_paused_n;
      rinse    <= (w_state_n == ST_RINSE) && !w_paused_n;
      drain    <= (w_state_n == ST_DRAIN) && !w_paused_n;
      spin     <= (w_state_n == ST_SPIN)  && !w_paused_n;
      busy     <= (w_state_n != ST_IDLE);
      paused   <= w_paused_n;
      done     <= w_done_n;
      aborted  <= w_abtd_n;
    end
  end

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Bench for wm_cycle_ctrl: phase-list reference model plus directed and random scenarios.
module tb_wm_cycle_ctrl;
  import wm_pkg::*;

  localparam int FILL_T  = 4;
  localparam int WASH_T  = 10;
  localparam int RINSE_T = 6;
  localparam int DRAIN_T = 3;
  localparam int SPIN_T  = 8;
  localparam int N_RINSE = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic pause = 1'b0;
  logic door_open = 1'b0;
  logic abort = 1'b0;
  logic fill, wash, rinse, drain, spin, busy, paused, done, aborted;
  logic [2:0] state;
  logic [11:0] w_obs;

  int n_vec = 0;
  int n_err = 0;

  wm_cycle_ctrl #(.CNT_W(8), .FILL_T(FILL_T), .WASH_T(WASH_T), .RINSE_T(RINSE_T),
                  .DRAIN_T(DRAIN_T), .SPIN_T(SPIN_T), .N_RINSE(N_RINSE)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .pause(pause),
    .door_open(door_open), .abort(abort), .fill(fill), .wash(wash), .rinse(rinse),
    .drain(drain), .spin(spin), .busy(busy), .paused(paused), .done(done),
    .aborted(aborted), .state(state)
  );

  always #5 clk = ~clk;

  assign w_obs = {fill, wash, rinse, drain, spin, busy, paused, done, aborted, state};

  // Reference model: the programme is a list of (actuator, length) phases.
  typedef struct { wm_state_t act; int len; } ph_t;
  ph_t m_q[$];
  int  m_idx, m_used;
  bit  m_busy, m_indone, m_frozen, m_abmode;
  logic [1:0] m_mode;

  function automatic int scl(int t, logic [1:0] md, bit is_wash);
    if (md == 2'd1) return (t / 2 < 1) ? 1 : t / 2;
    if (md == 2'd2 && is_wash) return 2 * t;
    return t;
  endfunction

  task automatic m_build(input logic [1:0] md);
    int r;
    m_q.delete();
    if (md != 2'd3) begin
      m_q.push_back('{ST_FILL, scl(FILL_T, md, 0)});
      m_q.push_back('{ST_WASH, scl(WASH_T, md, 1)});
      m_q.push_back('{ST_DRAIN, scl(DRAIN_T, md, 0)});
    end
    r = N_RINSE + ((md == 2'd2) ? 1 : 0);
    for (int k = 0; k < r; k++) begin
      m_q.push_back('{ST_FILL, scl(FILL_T, md, 0)});
      m_q.push_back('{ST_RINSE, scl(RINSE_T, md, 0)});
      m_q.push_back('{ST_DRAIN, scl(DRAIN_T, md, 0)});
    end
    m_q.push_back('{ST_SPIN, scl(SPIN_T, md, 0)});
  endtask

  task automatic m_reset();
    m_q.delete();
    m_idx = 0; m_used = 0; m_busy = 0; m_indone = 0; m_frozen = 0; m_abmode = 0; m_mode = 0;
  endtask

  task automatic m_step(input bit st, input logic [1:0] md, input bit ps, input bit dr, input bit ab);
    bit p;
    p = ps | dr;
    if (!m_busy) begin
      if (st && !dr) begin
        m_mode = md; m_build(md);
        m_idx = 0; m_used = 0; m_busy = 1; m_indone = 0; m_abmode = 0; m_frozen = p;
      end
    end else if (m_indone) begin
      m_busy = 0; m_indone = 0; m_abmode = 0; m_frozen = 0;
    end else if (ab && !m_abmode) begin
      m_abmode = 1;
      m_q.delete();
      m_q.push_back('{ST_DRAIN, scl(DRAIN_T, m_mode, 0)});
      m_idx = 0; m_used = 0; m_frozen = 0;
    end else begin
      if (!m_frozen) begin
        m_used++;
        if (m_used == m_q[m_idx].len) begin
          m_idx++; m_used = 0;
          if (m_idx == m_q.size()) m_indone = 1;
        end
      end
      m_frozen = p && !m_indone && !m_abmode;
    end
  endtask

  function automatic logic [11:0] exp_vec();
    logic [11:0] v;
    wm_state_t a;
    bit f;
    v = '0;
    if (m_busy) begin
      if (m_indone) begin
        v = {5'b0, 1'b1, 1'b0, !m_abmode, m_abmode, 3'(ST_DONE)};
      end else begin
        a = m_q[m_idx].act;
        f = m_frozen;
        v = {a == ST_FILL && !f, a == ST_WASH && !f, a == ST_RINSE && !f, a == ST_DRAIN && !f,
             a == ST_SPIN && !f, 1'b1, f, 2'b0, 3'(a)};
      end
    end
    return v;
  endfunction

  task automatic tick(input bit st, input logic [1:0] md, input bit ps, input bit dr, input bit ab);
    @(negedge clk);
    start = st; mode = md; pause = ps; door_open = dr; abort = ab;
    @(posedge clk);
    m_step(st, md, ps, dr, ab);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    reset = 1'b1;
    #12;
    m_reset();
    e = exp_vec();
    n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL reset_state got=%b exp=%b", w_obs, e); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_modes();
    int exp_len[4] = '{38, 18, 61, 21};
    int fill_at, done_at, busy_cnt, i;
    logic [11:0] e;
    for (int md = 0; md < 4; md++) begin
      fill_at = -1; done_at = -1; busy_cnt = 0;
      tick(1, 2'(md), 0, 0, 0);
      for (i = 0; i < 200; i++) begin
        if (i > 0) tick(0, 2'(md), 0, 0, 0);
        e = exp_vec();
        n_vec++;
        if (w_obs !== e) begin n_err++; $display("FAIL mode%0d_cycle i=%0d got=%b exp=%b", md, i, w_obs, e); end
        if (fill && fill_at < 0) fill_at = i;
        if (done && done_at < 0) done_at = i;
        if (busy) busy_cnt++;
        if (!busy && !m_busy) break;
      end
      n_vec++;
      if (i >= 200) begin n_err++; $display("FAIL mode%0d_timeout got=busy exp=idle", md); end
      n_vec++;
      if (fill_at != 0 || done_at - fill_at != exp_len[md]) begin
        n_err++; $display("FAIL mode%0d_done_latency got=%0d exp=%0d", md, done_at - fill_at, exp_len[md]);
      end
      n_vec++;
      if (busy_cnt != exp_len[md] + 1) begin
        n_err++; $display("FAIL mode%0d_busy_cycles got=%0d exp=%0d", md, busy_cnt, exp_len[md] + 1);
      end
    end
  endtask

  task automatic test_pause();
    int done_at, wash_cnt, i;
    bit ps;
    logic [11:0] e;
    done_at = -1; wash_cnt = 0;
    tick(1, 2'd0, 0, 0, 0);
    for (i = 0; i < 200; i++) begin
      ps = (i >= 7 && i <= 11);
      if (i > 0) tick(0, 2'd0, ps, 0, 0);
      e = exp_vec();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL pause_cycle i=%0d got=%b exp=%b", i, w_obs, e); end
      if (i == 9) begin
        n_vec++;
        if ({wash, paused, state} !== {1'b0, 1'b1, 3'(ST_WASH)}) begin
          n_err++; $display("FAIL pause_frozen got=%b exp=%b", {wash, paused, state}, {1'b0, 1'b1, 3'(ST_WASH)});
        end
      end
      if (wash) wash_cnt++;
      if (done && done_at < 0) done_at = i;
      if (!busy && !m_busy) break;
    end
    n_vec++;
    if (done_at != 43) begin n_err++; $display("FAIL pause_done_delay got=%0d exp=43", done_at); end
    n_vec++;
    if (wash_cnt != WASH_T) begin n_err++; $display("FAIL pause_wash_total got=%0d exp=%0d", wash_cnt, WASH_T); end
  endtask

  task automatic test_door();
    int done_at, i;
    bit dr;
    logic [11:0] e;
    for (int k = 0; k < 3; k++) begin
      tick(1, 2'd0, 0, 1, 0);
      e = exp_vec();
      n_vec++;
      if (w_obs !== e || busy !== 1'b0) begin n_err++; $display("FAIL door_blocks_start got=%b exp=%b", w_obs, e); end
    end
    done_at = -1;
    tick(1, 2'd0, 0, 0, 0);
    for (i = 0; i < 200; i++) begin
      dr = (i == 32 || i == 33);
      if (i > 0) tick(0, 2'd0, 0, dr, 0);
      e = exp_vec();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL door_cycle i=%0d got=%b exp=%b", i, w_obs, e); end
      if (done && done_at < 0) done_at = i;
      if (!busy && !m_busy) break;
    end
    n_vec++;
    if (done_at != 40) begin n_err++; $display("FAIL door_done_delay got=%0d exp=40", done_at); end
  endtask

  task automatic test_abort();
    int drain_cnt, ab_seen, dn_seen, i;
    logic [11:0] e;
    drain_cnt = 0; ab_seen = 0; dn_seen = 0;
    tick(1, 2'd0, 0, 0, 0);
    for (i = 0; i < 200; i++) begin
      if (i > 0) tick(i == 25, 2'd1, (i >= 23 && i <= 27), 0, (i == 23 || i == 24));
      e = exp_vec();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL abort_cycle i=%0d got=%b exp=%b", i, w_obs, e); end
      if (i >= 23 && drain) drain_cnt++;
      if (aborted) ab_seen++;
      if (done) dn_seen++;
      if (!busy && !m_busy) break;
    end
    n_vec++;
    if (drain_cnt != DRAIN_T) begin n_err++; $display("FAIL abort_drain_len got=%0d exp=%0d", drain_cnt, DRAIN_T); end
    n_vec++;
    if (ab_seen != 1 || dn_seen != 0) begin
      n_err++; $display("FAIL abort_pulses got=aborted%0d/done%0d exp=aborted1/done0", ab_seen, dn_seen);
    end
    n_vec++;
    if (i != 27) begin n_err++; $display("FAIL abort_idle_at got=%0d exp=27", i); end
  endtask

  task automatic test_async_reset();
    int done_at, i;
    logic [11:0] e;
    tick(1, 2'd0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) tick(0, 2'd0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    m_reset();
    e = exp_vec();
    n_vec++;
    if (w_obs !== e) begin n_err++; $display("FAIL async_reset_immediate got=%b exp=%b", w_obs, e); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    done_at = -1;
    tick(1, 2'd0, 0, 0, 0);
    for (i = 0; i < 200; i++) begin
      if (i > 0) tick(0, 2'd0, 0, 0, 0);
      e = exp_vec();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL post_reset_cycle i=%0d got=%b exp=%b", i, w_obs, e); end
      if (done && done_at < 0) done_at = i;
      if (!busy && !m_busy) break;
    end
    n_vec++;
    if (done_at != 38) begin n_err++; $display("FAIL post_reset_done got=%0d exp=38", done_at); end
  endtask

  task automatic test_random();
    logic [11:0] e;
    int i;
    for (int k = 0; k < 2000; k++) begin
      tick(($urandom_range(3) == 0), 2'($urandom_range(3)), ($urandom_range(7) == 0),
           ($urandom_range(15) == 0), ($urandom_range(63) == 0));
      e = exp_vec();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL random_cycle k=%0d got=%b exp=%b", k, w_obs, e); end
    end
    for (i = 0; i < 200; i++) begin
      if (!m_busy) break;
      tick(0, 2'd0, 0, 0, 0);
      e = exp_vec();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL random_drain i=%0d got=%b exp=%b", i, w_obs, e); end
    end
    n_vec++;
    if (i >= 200) begin n_err++; $display("FAIL random_timeout got=busy exp=idle"); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_modes();
    test_pause();
    test_door();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
